// File: rtl/shift_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shift_ctrl                                                     |
// | Purpose  : Two-requester sequencer and arbiter that shares one 16-bit     |
// |            SLL/SRA barrel shifter. SRL is built by masking an SRA.        |
// |            ROR is built from an SLL pass and a masked SRA pass. Each      |
// |            accepted request produces one tagged result on a valid/ready   |
// |            response channel.                                              |
// | Options  : SHIFT_CTRL_FIXED_PRIO_EN - requester 0 always wins a conflict  |
// |            (RR pointer and RR_INIT unused). Undefined: round-robin.       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module shift_ctrl #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_amt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_amt,
  input  logic [1:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_data,
  output logic        busy
);

  // Operation encodings on reqN_op
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // Sequencer states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC1 = 2'd1;
  localparam logic [1:0] S_EXEC2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Shifter native modes
  localparam logic MODE_SLL = 1'b0;
  localparam logic MODE_SRA = 1'b1;

  logic [1:0]  state_q, state_d;
  logic [15:0] data_q;
  logic [3:0]  amt_q;
  logic [1:0]  op_q;
  logic        id_q;
  logic [15:0] tmp_q;
  logic        resp_id_q;
  logic [15:0] resp_data_q;

  logic        grant0, grant1;
  logic        accept;
  logic [15:0] sh_in;
  logic [3:0]  sh_val;
  logic        sh_mode;
  logic [15:0] sh_out;
  logic [15:0] rmask;
  logic [15:0] exec1_result;
  logic [15:0] exec2_result;

  // --------------------------------------------------------------------------
  // Arbitration. Grants are purely combinational from the valids (and the
  // round-robin pointer), so at most one grant is ever high.
  // --------------------------------------------------------------------------
`ifdef SHIFT_CTRL_FIXED_PRIO_EN
  assign grant0 = req0_valid;
  assign grant1 = req1_valid && !req0_valid;
`else
  // rr_q names the requester that wins when both are valid.
  logic rr_q;

  assign grant0 = req0_valid && (!req1_valid || (rr_q == 1'b0));
  assign grant1 = req1_valid && (!req0_valid || (rr_q == 1'b1));

  // Round-robin pointer: hand priority to the requester that just lost out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= RR_INIT;
    end else if (accept) begin
      rr_q <= grant0 ? 1'b1 : 1'b0;
    end
  end
`endif

  // Ready only while idle; held low during reset so nothing is offered
  // until the sequencer is known to be in IDLE.
  assign req0_ready = !rst && (state_q == S_IDLE) && grant0;
  assign req1_ready = !rst && (state_q == S_IDLE) && grant1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // --------------------------------------------------------------------------
  // Shared shifter inputs: quiet (all zero) outside the execute states.
  // ROR's first pass is a left shift by (16 - amt) mod 16, which is simply
  // the 4-bit two's complement of amt.
  // --------------------------------------------------------------------------
  always_comb begin
    sh_in   = 16'h0000;
    sh_val  = 4'd0;
    sh_mode = MODE_SLL;
    case (state_q)
      S_EXEC1: begin
        sh_in = data_q;
        case (op_q)
          OP_SLL: begin sh_mode = MODE_SLL; sh_val = amt_q;        end
          OP_SRA: begin sh_mode = MODE_SRA; sh_val = amt_q;        end
          OP_SRL: begin sh_mode = MODE_SRA; sh_val = amt_q;        end
          OP_ROR: begin sh_mode = MODE_SLL; sh_val = 4'd0 - amt_q; end
          default: begin sh_mode = MODE_SLL; sh_val = 4'd0;        end
        endcase
      end
      S_EXEC2: begin
        sh_in   = data_q;
        sh_mode = MODE_SRA;
        sh_val  = amt_q;
      end
      default: begin
        sh_in   = 16'h0000;
        sh_val  = 4'd0;
        sh_mode = MODE_SLL;
      end
    endcase
  end

  // Shared barrel shifter: logical left or arithmetic right.
  always_comb begin
    if (sh_mode == MODE_SRA) begin
      sh_out = $signed(sh_in) >>> sh_val;
    end else begin
      sh_out = sh_in << sh_val;
    end
  end

  // Mask that clears the sign-extended bits an SRA drags in from the top.
  assign rmask = 16'hFFFF >> amt_q;

  // Result selection for the single-pass operations.
  always_comb begin
    case (op_q)
      OP_SRL:  exec1_result = sh_out & rmask;
      default: exec1_result = sh_out;
    endcase
  end

  // ROR second pass: low part from the masked right shift, high part from
  // the left-shifted first pass. With amt==0 the first pass is the operand
  // itself, so it must be dropped to avoid ORing it in twice.
  assign exec2_result = (sh_out & rmask) | ((amt_q == 4'd0) ? 16'h0000 : tmp_q);

  // Next-state logic for the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC1;
      S_EXEC1: state_d = (op_q == OP_ROR) ? S_EXEC2 : S_DONE;
      S_EXEC2: state_d = S_DONE;
      S_DONE:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request capture, ROR scratch and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= 16'h0000;
      amt_q       <= 4'd0;
      op_q        <= OP_SLL;
      id_q        <= 1'b0;
      tmp_q       <= 16'h0000;
      resp_id_q   <= 1'b0;
      resp_data_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            id_q   <= grant1;
            data_q <= grant1 ? req1_data : req0_data;
            amt_q  <= grant1 ? req1_amt  : req0_amt;
            op_q   <= grant1 ? req1_op   : req0_op;
          end
        end
        S_EXEC1: begin
          if (op_q == OP_ROR) begin
            tmp_q <= sh_out;
          end else begin
            resp_data_q <= exec1_result;
            resp_id_q   <= id_q;
          end
        end
        S_EXEC2: begin
          resp_data_q <= exec2_result;
          resp_id_q   <= id_q;
        end
        default: begin
          // DONE holds the response stable until it is taken.
        end
      endcase
    end
  end

  assign resp_valid = (state_q == S_DONE);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_shift_ctrl                                                  |
// | Purpose  : Self-checking bench for shift_ctrl: a vector table of single   |
// |            operations plus sequences for arbitration, backpressure and    |
// |            reset in the middle of a ROR.                                  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_shift_ctrl;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;
  localparam int         NVEC   = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic [1:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [15:0] resp_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          who;
    logic [15:0] data;
    logic [3:0]  amt;
    logic [1:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  shift_ctrl #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit who, input logic v, input logic [15:0] d,
                         input logic [3:0] a, input logic [1:0] o);
    if (who == 1'b0) begin
      req0_valid = v; req0_data = d; req0_amt = a; req0_op = o;
    end else begin
      req1_valid = v; req1_data = d; req1_amt = a; req1_op = o;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for resp_valid; returns the number of edges counted from
  // the accept edge inclusive, or 99 on timeout.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 12) begin
      tick();
      lat++;
    end
    if (!resp_valid) lat = 99;
  endtask

  // One operation from idle with resp_ready high: ready, latency, data, id.
  task automatic do_op(input string tag, input bit who, input logic [15:0] d,
                       input logic [3:0] a, input logic [1:0] o, input logic [15:0] exp);
    int lat;
    resp_ready = 1'b1;
    set_req(who, 1'b1, d, a, o);
    #1;
    check({tag, " ready"}, {30'd0, req1_ready, req0_ready}, who ? 32'd2 : 32'd1);
    tick();                                   // accept edge
    set_req(who, 1'b0, d, a, o);
    wait_resp(lat);
    check({tag, " latency"}, lat, (o == OP_ROR) ? 32'd3 : 32'd2);
    check({tag, " data"}, {16'd0, resp_data}, {16'd0, exp});
    check({tag, " id"}, {31'd0, resp_id}, {31'd0, who});
    tick();                                   // handshake edge
    check({tag, " idle after handshake"}, {30'd0, resp_valid, busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 16'h00F1, 4'd4,  OP_SLL, 16'h0F10};
    vecs[1]  = '{1'b1, 16'h8000, 4'd3,  OP_SRA, 16'hF000};
    vecs[2]  = '{1'b1, 16'h8000, 4'd3,  OP_SRL, 16'h1000};
    vecs[3]  = '{1'b0, 16'h1234, 4'd4,  OP_ROR, 16'h4123};
    vecs[4]  = '{1'b1, 16'hBEEF, 4'd0,  OP_ROR, 16'hBEEF};
    vecs[5]  = '{1'b0, 16'h0001, 4'd15, OP_ROR, 16'h0002};
    vecs[6]  = '{1'b0, 16'h7FF0, 4'd4,  OP_SRA, 16'h07FF};
    vecs[7]  = '{1'b1, 16'hFFFF, 4'd15, OP_SLL, 16'h8000};
    vecs[8]  = '{1'b0, 16'hFFFF, 4'd15, OP_SRL, 16'h0001};
    vecs[9]  = '{1'b1, 16'h8001, 4'd15, OP_SRA, 16'hFFFF};
    vecs[10] = '{1'b0, 16'hABCD, 4'd0,  OP_SRL, 16'hABCD};
    vecs[11] = '{1'b1, 16'h8001, 4'd1,  OP_ROR, 16'hC000};
    vecs[12] = '{1'b0, 16'h1234, 4'd0,  OP_SLL, 16'h1234};

    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_op = '0;
    req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_op = '0;

    // ---------------- reset state ----------------
    do_reset();
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_id",    {31'd0, resp_id},    32'd0);
    check("reset resp_data",  {16'd0, resp_data},  32'd0);
    check("reset readys",     {30'd0, req1_ready, req0_ready}, 32'd0);
    check("reset busy",       {31'd0, busy},       32'd0);

    // ---------------- vector table ----------------
    for (int i = 0; i < NVEC; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].who, vecs[i].data, vecs[i].amt,
            vecs[i].op, vecs[i].exp);
    end

    // ---------------- arbitration with both requesters valid ----------------
    begin
      bit grants [4];
      int ng = 0;
      bit expg [4];
      do_reset();
      resp_ready = 1'b1;
`ifdef SHIFT_CTRL_FIXED_PRIO_EN
      expg = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      expg = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      set_req(1'b0, 1'b1, 16'h0001, 4'd1, OP_SLL);
      set_req(1'b1, 1'b1, 16'h0001, 4'd2, OP_SLL);
      for (int c = 0; c < 40 && ng < 4; c++) begin
        #1;
        check("arb one-hot ready", {31'd0, req0_ready && req1_ready}, 32'd0);
        if (req0_ready || req1_ready) begin
          grants[ng] = req1_ready;
          ng++;
        end
        tick();
      end
      check("arb grant count", ng, 32'd4);
      for (int g = 0; g < 4; g++) begin
        check($sformatf("arb grant%0d", g), {31'd0, grants[g]}, {31'd0, expg[g]});
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int c = 0; c < 6 && busy; c++) tick();
      check("arb drained", {31'd0, busy}, 32'd0);
    end

    // ---------------- backpressure in DONE ----------------
    begin
      int lat;
      do_reset();
      resp_ready = 1'b0;
      set_req(1'b0, 1'b1, 16'h8000, 4'd1, OP_SRA);
      tick();
      set_req(1'b0, 1'b0, 16'h8000, 4'd1, OP_SRA);
      set_req(1'b1, 1'b1, 16'h0003, 4'd2, OP_SLL);
      wait_resp(lat);
      check("bp latency", lat, 32'd2);
      for (int c = 0; c < 5; c++) begin
        check($sformatf("bp hold%0d valid", c), {31'd0, resp_valid}, 32'd1);
        check($sformatf("bp hold%0d data",  c), {16'd0, resp_data}, 32'h0000_C000);
        check($sformatf("bp hold%0d id",    c), {31'd0, resp_id},    32'd0);
        check($sformatf("bp hold%0d readys", c), {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
      end
      resp_ready = 1'b1;
      tick();                                 // handshake edge
      #1;
      check("bp resume req1_ready", {31'd0, req1_ready}, 32'd1);
      tick();                                 // accept edge for requester 1
      set_req(1'b1, 1'b0, 16'h0003, 4'd2, OP_SLL);
      check("bp resume busy", {31'd0, busy}, 32'd1);
      wait_resp(lat);
      check("bp resume data", {16'd0, resp_data}, 32'h0000_000C);
      check("bp resume id",   {31'd0, resp_id},   32'd1);
      tick();
    end

    // ---------------- reset during EXEC2 of a ROR ----------------
    begin
      bit seen = 1'b0;
      resp_ready = 1'b1;
      set_req(1'b0, 1'b1, 16'h1234, 4'd4, OP_ROR);
      tick();                                 // accept -> EXEC1
      set_req(1'b0, 1'b0, 16'h1234, 4'd4, OP_ROR);
      tick();                                 // -> EXEC2
      check("midrst in exec", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
      check("midrst busy",       {31'd0, busy},       32'd0);
      check("midrst resp_id",    {31'd0, resp_id},    32'd0);
      check("midrst resp_data",  {16'd0, resp_data},  32'd0);
      for (int c = 0; c < 4; c++) begin
        if (resp_valid) seen = 1'b1;
        tick();
      end
      check("midrst no response", {31'd0, seen}, 32'd0);
      do_op("post-reset SLL", 1'b0, 16'h00F1, 4'd4, OP_SLL, 16'h0F10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
